// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types and constants for the sequential arithmetic unit
//
// Purpose : FSM state encoding, default operand width and step-counter sizing
//           used by arith_seq_unit and arith_shift_divider.
// Ports   : none (package)
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int ARITH_CNT_W = cnt_width(ARITH_WIDTH);

endpackage

// File: rtl/arith_shift_divider.sv
// rtl/arith_shift_divider.sv - unsigned restoring divider, one quotient bit per step
//
// Purpose : Loads dividend/divisor on start, then on each step shifts one
//           dividend bit into the partial remainder and performs a trial
//           subtraction. After WIDTH steps quotient = floor(a/b) and
//           remainder = a mod b. A zero divisor needs no special handling:
//           every trial succeeds, giving quotient all ones and remainder a.
// Ports   : clock, reset (sync, active-high)
//           start     - load operands, clear quotient/remainder
//           step      - perform one restoring iteration
//           dividend  - operand a, divisor - operand b
//           quotient  - quotient register
//           remainder - partial/final remainder register
module arith_shift_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    // Shifted remainder is one bit wider than the divisor path so the
    // compare cannot lose the remainder MSB.
    logic [WIDTH:0]   trial;

    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        rem_d = rem_q;
        trial = {rem_q, dvd_q[WIDTH-1]};
        if (start) begin
            dvd_d = dividend;
            dvs_d = divisor;
            quo_d = '0;
            rem_d = '0;
        end else if (step) begin
            dvd_d = dvd_q << 1;
            if (trial >= {1'b0, dvs_q}) begin
                // Difference is below the divisor, so the low WIDTH bits suffice.
                rem_d = trial[WIDTH-1:0] - dvs_q;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dvd_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/arith_seq_unit.sv
// rtl/arith_seq_unit.sv - sequential add/sub/mul/div responder with valid/ready handshakes
//
// Purpose : Accepts an operand pair when idle, registers add/sub at once,
//           runs WIDTH shift-add multiply and restoring divide steps, then
//           presents all results with o_valid until the consumer takes them.
//           o_valid rises WIDTH+1 clocks after the accept edge.
// Ports   : clock, reset (sync, active-high)
//           i_valid/o_ready, i_value_a, i_value_b   - operand handshake
//           o_valid/i_ready                         - result handshake
//           o_result_add/sub/mul/div, o_div_by_zero - results (held in DONE)
//           o_result_rem                            - only with ARITH_REMAINDER_EN
// Config  : ARITH_REMAINDER_EN exports the divider remainder as o_result_rem.
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_value_a,
    input  logic [WIDTH-1:0] i_value_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result_add,
    output logic [WIDTH-1:0] o_result_sub,
    output logic [WIDTH-1:0] o_result_mul,
    output logic [WIDTH-1:0] o_result_div,
    output logic             o_div_by_zero
`ifdef ARITH_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] o_result_rem
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    arith_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] add_q;
    logic [WIDTH-1:0] sub_q;
    logic             dbz_q;
    logic             valid_q;

    logic             accept;
    logic             div_step;
    logic [WIDTH-1:0] div_quo;

    assign o_ready  = (state_q == ST_IDLE);
    assign accept   = i_valid && (state_q == ST_IDLE);
    // The counter reaching zero marks the extra finishing cycle in CALC.
    assign div_step = (state_q == ST_CALC) && (cnt_q != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            add_q   <= '0;
            sub_q   <= '0;
            dbz_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_CALC;
                        cnt_q   <= CNT_W'(WIDTH);
                        a_sh_q  <= i_value_a;
                        b_sh_q  <= i_value_b;
                        acc_q   <= '0;
                        add_q   <= i_value_a + i_value_b;
                        sub_q   <= i_value_a - i_value_b;
                        dbz_q   <= (i_value_b == '0);
                    end
                end
                ST_CALC: begin
                    if (cnt_q != '0) begin
                        // Low WIDTH bits only, so a_sh may drop its MSB freely.
                        if (b_sh_q[0]) begin
                            acc_q <= acc_q + a_sh_q;
                        end
                        a_sh_q <= a_sh_q << 1;
                        b_sh_q <= b_sh_q >> 1;
                        cnt_q  <= cnt_q - CNT_W'(1);
                    end else begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARITH_REMAINDER_EN
    logic [WIDTH-1:0] div_rem;
`else
    logic [WIDTH-1:0] div_rem_unused;
`endif

    arith_shift_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (accept),
        .step     (div_step),
        .dividend (i_value_a),
        .divisor  (i_value_b),
        .quotient (div_quo),
`ifdef ARITH_REMAINDER_EN
        .remainder(div_rem)
`else
        .remainder(div_rem_unused)
`endif
    );

    assign o_valid       = valid_q;
    assign o_result_add  = add_q;
    assign o_result_sub  = sub_q;
    assign o_result_mul  = acc_q;
    assign o_result_div  = div_quo;
    assign o_div_by_zero = dbz_q;
`ifdef ARITH_REMAINDER_EN
    assign o_result_rem  = div_rem;
`endif

endmodule

// File: tb/tb_arith_seq_unit.sv
// tb/tb_arith_seq_unit.sv - self-checking bench for arith_seq_unit
module tb_arith_seq_unit;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_value_a;
    logic [W-1:0] i_value_b;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result_add;
    logic [W-1:0] o_result_sub;
    logic [W-1:0] o_result_mul;
    logic [W-1:0] o_result_div;
    logic         o_div_by_zero;
`ifdef ARITH_REMAINDER_EN
    logic [W-1:0] o_result_rem;
`endif

    arith_seq_unit #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_value_a    (i_value_a),
        .i_value_b    (i_value_b),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result_add (o_result_add),
        .o_result_sub (o_result_sub),
        .o_result_mul (o_result_mul),
        .o_result_div (o_result_div),
`ifdef ARITH_REMAINDER_EN
        .o_div_by_zero(o_div_by_zero),
        .o_result_rem (o_result_rem)
`else
        .o_div_by_zero(o_div_by_zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] add;
        logic [W-1:0] sub;
        logic [W-1:0] mul;
        logic [W-1:0] div;
        logic [W-1:0] rem;
        logic         dbz;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t ref_vec(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        logic [2*W-1:0] prod;
        prod  = a * b;
        v.a   = a;
        v.b   = b;
        v.add = a + b;
        v.sub = a - b;
        v.mul = prod[W-1:0];
        v.div = (b == 0) ? {W{1'b1}} : a / b;
        v.rem = (b == 0) ? a : a % b;
        v.dbz = (b == 0);
        return v;
    endfunction

    task automatic cmp_res(input vec_t v);
        chk("add", o_result_add, v.add);
        chk("sub", o_result_sub, v.sub);
        chk("mul", o_result_mul, v.mul);
        chk("div", o_result_div, v.div);
        chk("div_by_zero", o_div_by_zero, v.dbz);
`ifdef ARITH_REMAINDER_EN
        chk("rem", o_result_rem, v.rem);
`endif
    endtask

    task automatic send(input vec_t v);
        int w;
        w = 0;
        while (!o_ready && w < 40) begin
            @(negedge clock);
            w++;
        end
        if (!o_ready) chk("ready_timeout", 0, 1);
        i_valid   = 1'b1;
        i_value_a = v.a;
        i_value_b = v.b;
        sb.push_back('{v: v, acc_cyc: cyc + 1});
        @(negedge clock);
        i_valid   = 1'b0;
        // Operand changes after the accept edge must not matter.
        i_value_a = W'($urandom);
        i_value_b = W'($urandom);
    endtask

    task automatic get_result(input int hold);
        exp_t e;
        int   w;
        w = 0;
        while (!o_valid && w < 40) begin
            @(negedge clock);
            w++;
        end
        if (!o_valid) begin
            chk("valid_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
            i_ready = 1'b1;
            i_valid = 1'b0;
            return;
        end
        if (sb.size() == 0) begin
            chk("unexpected_result", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("latency", cyc - e.acc_cyc, 9);
        chk("ready_in_done", o_ready, 0);
        cmp_res(e.v);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("hold_valid", o_valid, 1);
            chk("hold_ready", o_ready, 0);
            cmp_res(e.v);
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        @(negedge clock);
        chk("post_valid", o_valid, 0);
        chk("post_ready", o_ready, 1);
    endtask

    initial begin
        vec_t v;
        reset     = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_value_a = '0;
        i_value_b = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_add", o_result_add, 0);
        chk("rst_mul", o_result_mul, 0);
        chk("rst_div", o_result_div, 0);
        chk("rst_dbz", o_div_by_zero, 0);

        //            a    b    add  sub  mul  div  rem  dbz
        tbl[0]  = '{8'd20,  8'd10,  8'd30,  8'd10,  8'd200, 8'd2,   8'd0, 1'b0};
        tbl[1]  = '{8'd250, 8'd10,  8'd4,   8'd240, 8'd196, 8'd25,  8'd0, 1'b0};
        tbl[2]  = '{8'd5,   8'd10,  8'd15,  8'd251, 8'd50,  8'd0,   8'd5, 1'b0};
        tbl[3]  = '{8'd7,   8'd0,   8'd7,   8'd7,   8'd0,   8'd255, 8'd7, 1'b1};
        tbl[4]  = '{8'd200, 8'd3,   8'd203, 8'd197, 8'd88,  8'd66,  8'd2, 1'b0};
        tbl[5]  = '{8'd255, 8'd255, 8'd254, 8'd0,   8'd1,   8'd1,   8'd0, 1'b0};
        tbl[6]  = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd0, 1'b1};
        tbl[7]  = '{8'd1,   8'd255, 8'd0,   8'd2,   8'd255, 8'd0,   8'd1, 1'b0};
        tbl[8]  = '{8'd128, 8'd2,   8'd130, 8'd126, 8'd0,   8'd64,  8'd0, 1'b0};
        tbl[9]  = '{8'd255, 8'd1,   8'd0,   8'd254, 8'd255, 8'd255, 8'd0, 1'b0};
        tbl[10] = '{8'd100, 8'd7,   8'd107, 8'd93,  8'd188, 8'd14,  8'd2, 1'b0};

        for (int i = 0; i < 11; i++) begin
            send(tbl[i]);
            get_result(0);
        end

        // Backpressure: results held for 5 clocks, a busy i_valid is ignored.
        i_ready = 1'b0;
        send(tbl[4]);
        i_valid   = 1'b1;
        i_value_a = 8'd9;
        i_value_b = 8'd9;
        get_result(5);
        repeat (12) @(negedge clock);
        chk("no_phantom_valid", o_valid, 0);
        chk("sb_drained", sb.size(), 0);

        // Reset in the middle of CALC discards the transaction.
        send(tbl[0]);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_add", o_result_add, 0);
        chk("mid_rst_sub", o_result_sub, 0);
        chk("mid_rst_mul", o_result_mul, 0);
        chk("mid_rst_div", o_result_div, 0);
        chk("mid_rst_dbz", o_div_by_zero, 0);
        sb.delete();
        send(tbl[0]);
        get_result(0);

        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 255));
            rb = (k % 16 == 0) ? '0 : W'($urandom_range(0, 255));
            v  = ref_vec(ra, rb);
            send(v);
            get_result(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
